// File: rtl/wb_serializer_fifo.sv
// Wishbone-slave serial transmitter. Words written to DATA are queued in a
// small circular FIFO and shifted out MSB-first on data_o. The bit period is
// div+1 clock cycles. Queued words follow one another with no idle gap.
`timescale 1ns/1ps
module wb_serializer_fifo #(
  parameter int SYM_W = 9,
  parameter int SYMS  = 3,
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        data_o,
  output logic        frame_o,
  output logic        eot_o
);

  localparam int W  = SYM_W * SYMS;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, level;
  logic             en, ovf;
  logic [DIV_W-1:0] div, div_cnt;
  state_t           state;
  logic [W-1:0]     sr;
  logic [BW-1:0]    bit_cnt;

  logic [1:0] adr;
  logic       acc, data_wr, ctrl_wr, stat_wr, flush;
  logic       empty, full, bit_end, last_bit, pop, drop, push;
  logic [W-1:0] head;
  logic       unused;

  assign unused = ^{ADR_I[31:2], DAT_I};

  // Bus decode; one register access per acknowledged cycle
  assign adr     = ADR_I[1:0];
  assign acc     = CYC_I & STB_I;
  assign data_wr = acc & WE_I & (adr == 2'd0);
  assign ctrl_wr = acc & WE_I & (adr == 2'd1);
  assign stat_wr = acc & WE_I & (adr == 2'd2);
  assign flush   = ctrl_wr & DAT_I[1];

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];

  // >= keeps a shrinking div from stretching the current bit for 2^DIV_W cycles
  assign bit_end  = (state == SHIFT) & (div_cnt >= div);
  assign last_bit = bit_end & (bit_cnt == BW'(W - 1));
  assign pop      = en & ~empty & ((state == IDLE) | last_bit);

  // A push at full is only refused when no pop frees a slot on the same edge
  assign drop  = data_wr & full & ~pop;
  assign push  = data_wr & ~drop & ~flush;
  assign ERR_O = acc & ((adr == 2'd3) | drop);
  assign ACK_O = acc & ~ERR_O;

  assign data_o  = sr[W-1];
  assign frame_o = (state == SHIFT) & (bit_cnt == '0);
  assign eot_o   = last_bit;

  // Combinational read mux so STATUS reflects the current cycle
  always_comb begin
    DAT_O = '0;
    case (adr)
      2'd1: begin
        DAT_O[0]           = en;
        DAT_O[16 +: DIV_W] = div;
      end
      2'd2: begin
        DAT_O[0]    = empty;
        DAT_O[1]    = full;
        DAT_O[2]    = (state == SHIFT);
        DAT_O[3]    = ovf;
        DAT_O[15:8] = 8'(level);
      end
      default: DAT_O = '0;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr[AW-1:0]] <= DAT_I[W-1:0];
  end

  // FIFO pointers; flush drops everything queued but not the word in flight
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Control and sticky overflow registers
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      en  <= 1'b0;
      div <= '0;
      ovf <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en  <= DAT_I[0];
        div <= DAT_I[16 +: DIV_W];
      end
      if (drop)                    ovf <= 1'b1;
      else if (stat_wr & DAT_I[3]) ovf <= 1'b0;
    end
  end

  // Shifter FSM; reloads on the last-bit edge so words are contiguous
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state   <= IDLE;
      sr      <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sr      <= head;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            if (pop) begin
              sr <= head;
            end else begin
              sr    <= '0;
              state <= IDLE;
            end
          end else if (bit_end) begin
            sr      <= sr << 1;
            bit_cnt <= bit_cnt + BW'(1);
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serializer_fifo.sv
// Bench for wb_serializer_fifo: directed scenarios plus random bus traffic,
// all checked cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_serializer_fifo;
  localparam int SYM_W = 9, SYMS = 3, DEPTH = 4, DIV_W = 16;
  localparam int W = SYM_W * SYMS;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1, CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [31:0] ADR_I = '0, DAT_I = '0, DAT_O;
  logic ACK_O, ERR_O, data_o, frame_o, eot_o;

  wb_serializer_fifo #(.SYM_W(SYM_W), .SYMS(SYMS), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .ERR_O(ERR_O),
    .data_o(data_o), .frame_o(frame_o), .eot_o(eot_o)
  );

  always #5 CLK_I = ~CLK_I;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: FIFO as a queue, current word as (word, elapsed cycles)
  logic [W-1:0]     m_q[$];
  bit               m_en = 0, m_ovf = 0, m_busy = 0;
  logic [DIV_W-1:0] m_div = '0;
  int               m_el = 0;
  logic [W-1:0]     m_word = '0;
  int               cyc_n = 0;
  int               eot_q[$];
  bit               mp_pop, mp_full;

  function automatic int m_len();
    return W * (int'(m_div) + 1);
  endfunction
  function automatic bit m_last();
    return m_busy && (m_el == m_len() - 1);
  endfunction
  function automatic bit m_pop();
    return m_en && (m_q.size() > 0) && (!m_busy || m_last());
  endfunction
  function automatic bit m_err();
    return (ADR_I[1:0] == 2'd3) ||
           (WE_I && ADR_I[1:0] == 2'd0 && m_q.size() == DEPTH && !m_pop());
  endfunction
  function automatic logic [31:0] m_rd();
    case (ADR_I[1:0])
      2'd1:    return {m_div, 15'd0, m_en};
      2'd2:    return {16'd0, 8'(m_q.size()), 4'd0, m_ovf, m_busy,
                       m_q.size() == DEPTH, m_q.size() == 0};
      default: return 32'd0;
    endcase
  endfunction

  // Model advance on each edge
  always @(posedge CLK_I) begin
    cyc_n++;
    if (RST_I) begin
      m_q.delete(); m_en = 0; m_ovf = 0; m_busy = 0; m_div = '0; m_el = 0; m_word = '0;
    end else begin
      mp_pop  = m_pop();
      mp_full = (m_q.size() == DEPTH);
      if (mp_pop) begin
        m_word = m_q.pop_front(); m_busy = 1; m_el = 0;
      end else if (m_busy) begin
        if (m_last()) m_busy = 0;
        else m_el++;
      end
      if (CYC_I && STB_I && WE_I) begin
        case (ADR_I[1:0])
          2'd0: if (mp_full && !mp_pop) m_ovf = 1; else m_q.push_back(DAT_I[W-1:0]);
          2'd1: begin
            m_en = DAT_I[0]; m_div = DAT_I[16 +: DIV_W];
            if (DAT_I[1]) m_q.delete();
          end
          2'd2: if (DAT_I[3]) m_ovf = 0;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge CLK_I) begin
    chk("data_o", data_o, m_busy ? m_word[W - 1 - m_el / (int'(m_div) + 1)] : 1'b0);
    chk("frame_o", frame_o, m_busy && (m_el < int'(m_div) + 1));
    chk("eot_o", eot_o, m_last());
    if (eot_o) eot_q.push_back(cyc_n);
    if (CYC_I && STB_I) begin
      chk("ack", ACK_O, !m_err());
      chk("err", ERR_O, m_err());
      if (!WE_I) chk("dat_o", DAT_O, m_rd());
    end else begin
      chk("bus_quiet", {ACK_O, ERR_O}, 0);
    end
  end

  logic [31:0] rdat;
  logic        rack, rerr;
  int          acc_cyc;

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK_I); #1; end
  endtask

  task automatic wb(input logic [1:0] a, input logic we, input logic [31:0] d);
    CYC_I = 1; STB_I = 1; WE_I = we; ADR_I = {30'd0, a}; DAT_I = d;
    @(negedge CLK_I);
    rdat = DAT_O; rack = ACK_O; rerr = ERR_O; acc_cyc = cyc_n;
    @(posedge CLK_I); #1;
    CYC_I = 0; STB_I = 0; WE_I = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_busy || (m_en && m_q.size() != 0)) && k < budget) begin step(1); k++; end
    chk("idle_timeout", k < budget, 1);
  endtask

  function automatic int first_eot_lat(input int p);
    return (eot_q.size() > 0) ? eot_q[0] - p : -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p, k, r;
    step(3);
    RST_I = 0;
    wb(2'd2, 0, 0);  chk("rst_status", rdat, 32'h1);
    chk("rst_data_o", data_o, 0);

    // Single word, div=0: eot lands 28 cycles after the push cycle
    wb(2'd1, 1, 32'h1);
    eot_q.delete();
    wb(2'd0, 1, 32'h5A5A5A5); p = acc_cyc;
    wait_idle(200);
    chk("t1_eot_n", eot_q.size(), 1);
    chk("t1_eot_lat", first_eot_lat(p), 28);
    wb(2'd2, 0, 0);  chk("t1_status", rdat, 32'h1);

    // Divider of 3: 108-cycle word
    wb(2'd1, 1, (32'd3 << 16) | 32'h1);
    eot_q.delete();
    wb(2'd0, 1, 32'h4000001); p = acc_cyc;
    wait_idle(400);
    chk("t2_eot_lat", first_eot_lat(p), 109);

    // Back-to-back with overflow
    wb(2'd1, 1, 32'h0);
    for (int i = 0; i < 4; i++) wb(2'd0, 1, $urandom);
    wb(2'd2, 0, 0);  chk("t3_full", rdat, 32'h402);
    wb(2'd0, 1, $urandom); chk("t3_ovf_err", rerr, 1);
    wb(2'd2, 0, 0);  chk("t3_ovf", rdat, 32'h40A);
    eot_q.delete();
    wb(2'd1, 1, 32'h1);
    wait_idle(400);
    chk("t3_eot_n", eot_q.size(), 4);
    for (int i = 1; i < eot_q.size(); i++) chk("t3_eot_gap", eot_q[i] - eot_q[i-1], 27);
    wb(2'd2, 0, 0);  chk("t3_done", rdat, 32'h9);
    wb(2'd2, 1, 32'h8);
    wb(2'd2, 0, 0);  chk("t3_w1c", rdat, 32'h1);

    // Push at full timed with eot
    wb(2'd1, 1, 32'h0);
    for (int i = 0; i < 4; i++) wb(2'd0, 1, $urandom);
    wb(2'd1, 1, 32'h1);
    wb(2'd0, 1, $urandom); chk("t4_refill_ack", rack, 1);
    k = 0;
    while (!m_last() && k < 100) begin step(1); k++; end
    chk("t4_wait", k < 100, 1);
    wb(2'd0, 1, $urandom); chk("t4_ack", rack, 1);
    wb(2'd2, 0, 0);  chk("t4_status", rdat, 32'h406);
    wait_idle(600);

    // Flush mid-word, then disable mid-word
    wb(2'd1, 1, 32'h0);
    for (int i = 0; i < 3; i++) wb(2'd0, 1, $urandom);
    eot_q.delete();
    wb(2'd1, 1, 32'h1);
    step(5);
    wb(2'd1, 1, 32'h3);
    wait_idle(200);
    chk("t5_flush_n", eot_q.size(), 1);
    wb(2'd2, 0, 0);  chk("t5_flush_st", rdat, 32'h1);
    eot_q.delete();
    wb(2'd0, 1, $urandom);
    wb(2'd0, 1, $urandom);
    step(5);
    wb(2'd1, 1, 32'h0);
    wait_idle(200);
    chk("t5_dis_n", eot_q.size(), 1);
    wb(2'd2, 0, 0);  chk("t5_dis_st", rdat, 32'h100);
    wb(2'd1, 1, 32'h2);
    wb(2'd2, 0, 0);  chk("t5_clear", rdat, 32'h1);

    // Reset mid-word and reserved address
    wb(2'd1, 1, 32'h1);
    wb(2'd0, 1, 32'h7FFFFFF);
    step(6);
    RST_I = 1; step(1); RST_I = 0;
    chk("t6_data_o", data_o, 0);
    wb(2'd2, 0, 0);  chk("t6_status", rdat, 32'h1);
    wb(2'd3, 0, 0);  chk("t6_err_rd", rerr, 1); chk("t6_ack_rd", rack, 0);
    wb(2'd3, 1, 32'h5); chk("t6_err_wr", rerr, 1);

    // Random traffic; div only changes here, while idle
    wb(2'd1, 1, (32'($urandom_range(0, 2)) << 16) | 32'h1);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      wb(2'd0, 1, $urandom);
      else if (r < 60) wb(2'd2, 0, 0);
      else if (r < 65) wb(2'd1, 0, 0);
      else if (r < 68) wb(2'd0, 0, 0);
      else if (r < 71) wb(2'd3, 1'($urandom_range(0, 1)), $urandom);
      else if (r < 76) wb(2'd2, 1, $urandom);
      else if (r < 84) wb(2'd1, 1, {m_div, 14'd0, 1'($urandom_range(0, 9) == 0),
                                    1'($urandom_range(0, 3) != 0)});
      else             step($urandom_range(1, 20));
    end
    wb(2'd1, 1, {m_div, 16'h1});
    wait_idle(2000);
    wb(2'd2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
